// File: rtl/snake_pkg.sv
// Heading encoding shared by the direction controller and the move/body logic.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // Opposite headings differ only in bit 0 with this encoding.
   function automatic logic [1:0] dir_opposite(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular FIFO of headings with head/tail peek; a pop in the same cycle
// frees the slot for a push even when full.
module dir_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] tail,
   output logic [2:0]       count,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr, tail_ptr;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (count == 3'(DEPTH));
   assign empty    = (count == 3'd0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign tail_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
   assign head     = mem[rd_ptr];
   assign tail     = mem[tail_ptr];

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= 3'd0;
         // NOTE: storage is reset too, so head/tail never drive X into the filter.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= 3'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + 3'd1;
         else if (do_pop && !do_push) count <= count - 3'd1;
      end
   end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: decodes key pulses, filters reversals/repeats,
// queues legal turns and commits one per move_tick.
module snake_dir_ctrl
   import snake_pkg::*;
#(
   parameter int         QDEPTH   = 2,
   parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_key_press,
   input  logic       right_key_press,
   input  logic       up_key_press,
   input  logic       down_key_press,
   input  logic       move_tick,
   input  logic       restart,
   output logic [1:0] dir,
   output logic       turn_pulse,
   output logic       reject_pulse,
   output logic [2:0] q_count
);

   logic       key_valid;
   logic [1:0] key_dir;
   logic [1:0] ref_dir, q_head, q_tail;
   logic       q_full, q_empty;
   logic       legal, do_push, do_pop, do_reject;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      key_valid = 1'b1;
      key_dir   = DIR_UP;
      if (up_key_press)         key_dir = DIR_UP;
      else if (down_key_press)  key_dir = DIR_DOWN;
      else if (left_key_press)  key_dir = DIR_LEFT;
      else if (right_key_press) key_dir = DIR_RIGHT;
      else                      key_valid = 1'b0;
   end

   // Compare against the last heading the snake will have, not the current one.
   assign ref_dir   = q_empty ? dir : q_tail;
   assign legal     = key_valid && (key_dir != ref_dir) && (key_dir != dir_opposite(ref_dir));
   assign do_pop    = move_tick && !q_empty && !restart;
   assign do_push   = legal && (!q_full || do_pop) && !restart;
   assign do_reject = key_valid && !restart && !do_push;

   dir_fifo #(
      .WIDTH (2),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (do_push),
      .pop   (do_pop),
      .flush (restart),
      .din   (key_dir),
      .head  (q_head),
      .tail  (q_tail),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir          <= INIT_DIR;
         turn_pulse   <= 1'b0;
         reject_pulse <= 1'b0;
      end else begin
         if (restart)     dir <= INIT_DIR;
         else if (do_pop) dir <= q_head;
         turn_pulse   <= do_pop;
         reject_pulse <= do_reject;
      end
   end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: directed scenarios plus random key/tick
// traffic, all compared against a queue-based heading model.
module tb_snake_dir_ctrl;

   localparam int QDEPTH = 2;
   localparam int INIT   = 3;

   logic       clk, reset;
   logic       left_key_press, right_key_press, up_key_press, down_key_press;
   logic       move_tick, restart;
   logic [1:0] dir;
   logic       turn_pulse, reject_pulse;
   logic [2:0] q_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: pending turns as a plain queue of heading numbers.
   int mq[$];
   int m_dir;
   int m_turn, m_rej;
   int opp_of[4] = '{1, 0, 3, 2};

   snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(2'd3)) dut (
      .clk             (clk),
      .reset           (reset),
      .left_key_press  (left_key_press),
      .right_key_press (right_key_press),
      .up_key_press    (up_key_press),
      .down_key_press  (down_key_press),
      .move_tick       (move_tick),
      .restart         (restart),
      .dir             (dir),
      .turn_pulse      (turn_pulse),
      .reject_pulse    (reject_pulse),
      .q_count         (q_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_dir  = INIT;
      m_turn = 0;
      m_rej  = 0;
   endtask

   task automatic model_step(input bit u, input bit d, input bit l, input bit r,
                             input bit tick, input bit rs);
      int key, refh;
      bit popping, illegal;
      if (rs) begin
         model_reset();
         return;
      end
      key = u ? 0 : d ? 1 : l ? 2 : r ? 3 : -1;
      refh = (mq.size() > 0) ? mq[$] : m_dir;
      popping = tick && (mq.size() > 0);
      m_turn = popping;
      m_rej  = 0;
      if (popping) m_dir = mq.pop_front();
      if (key >= 0) begin
         illegal = (key == refh) || (key == opp_of[refh]);
         if (illegal || (mq.size() >= QDEPTH)) m_rej = 1;
         else mq.push_back(key);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".dir"},     dir,          m_dir);
      check({tag, ".q_count"}, q_count,      mq.size());
      check({tag, ".turn"},    turn_pulse,   m_turn);
      check({tag, ".reject"},  reject_pulse, m_rej);
   endtask

   task automatic step(input string tag, input bit u, input bit d, input bit l, input bit r,
                       input bit tick, input bit rs);
      @(negedge clk);
      up_key_press    = u;
      down_key_press  = d;
      left_key_press  = l;
      right_key_press = r;
      move_tick       = tick;
      restart         = rs;
      model_step(u, d, l, r, tick, rs);
      @(posedge clk);
      #1;
      check_all(tag);
      {up_key_press, down_key_press, left_key_press, right_key_press, move_tick, restart} = '0;
   endtask

   initial begin
      reset = 1'b0;
      {up_key_press, down_key_press, left_key_press, right_key_press, move_tick, restart} = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // 1: queue UP, commit on tick
      step("t1_up",   1, 0, 0, 0, 0, 0);
      check("t1_qc", q_count, 1);
      step("t1_tick", 0, 0, 0, 0, 1, 0);
      check("t1_dir", dir, 0);
      check("t1_turn", turn_pulse, 1);
      step("t1_idle", 0, 0, 0, 0, 0, 0);
      step("t1_rst",  0, 0, 0, 0, 0, 1);

      // 2: reversal from RIGHT is rejected
      step("t2_left", 0, 0, 1, 0, 0, 0);
      check("t2_rej", reject_pulse, 1);
      step("t2_idle", 0, 0, 0, 0, 0, 0);
      step("t2_right", 0, 0, 0, 1, 0, 0);

      // 3: double-tap between ticks
      step("t3_up",    1, 0, 0, 0, 0, 0);
      step("t3_left",  0, 0, 1, 0, 0, 0);
      check("t3_qc", q_count, 2);
      step("t3_tick1", 0, 0, 0, 0, 1, 0);
      check("t3_dir1", dir, 0);
      step("t3_tick2", 0, 0, 0, 0, 1, 0);
      check("t3_dir2", dir, 2);
      step("t3_tick3", 0, 0, 0, 0, 1, 0);
      step("t3_rst",   0, 0, 0, 0, 0, 1);

      // 4: full queue, then push with simultaneous pop
      step("t4_up",     1, 0, 0, 0, 0, 0);
      step("t4_left",   0, 0, 1, 0, 0, 0);
      step("t4_down",   0, 1, 0, 0, 0, 0);
      check("t4_full_rej", reject_pulse, 1);
      step("t4_down_t", 0, 1, 0, 0, 1, 0);
      check("t4_qc", q_count, 2);
      check("t4_norej", reject_pulse, 0);
      step("t4_rst",    0, 0, 0, 0, 0, 1);

      // 5: up+left together: only UP, no reject
      step("t5_ul", 1, 0, 1, 0, 0, 0);
      check("t5_norej", reject_pulse, 0);
      step("t5_rst", 0, 0, 0, 0, 0, 1);

      // 6: restart overrides key and tick; async reset mid-queue
      step("t6_up",  1, 0, 0, 0, 0, 0);
      step("t6_all", 1, 1, 1, 1, 1, 1);
      check("t6_dir", dir, 3);
      step("t6_up2",   1, 0, 0, 0, 0, 0);
      step("t6_left2", 0, 0, 1, 0, 1, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all("t6_async");
      @(negedge clk);
      reset = 1'b1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(3) == 0), ($urandom_range(3) == 0),
              ($urandom_range(3) == 0), ($urandom_range(3) == 0),
              ($urandom_range(2) == 0), ($urandom_range(39) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
